// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone B3 classic arbiter.
// Round-robin grant held for a whole cyc, with a watchdog that ends
// stalled slave accesses by raising err to the granted master.
module wb_arbiter_2m #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [1:0]        grant_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          last;      // last-served master; 1 so m0 wins the first tie
  logic [CW-1:0] cnt;
  logic          mst_stb;
  logic          expire;

  // Next grant: arbitrate from IDLE, hold while cyc, hand off on release
  always_comb begin
    state_nxt = state;
    case (state)
      GNT0: begin
        if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
      end
      default: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
        else                      state_nxt = IDLE;
      end
    endcase
  end

  // Watchdog expiry: a stalled strobe that reached the limit with no reply
  always_comb begin
    mst_stb = 1'b0;
    if (state == GNT0) mst_stb = m0_stb_i;
    if (state == GNT1) mst_stb = m1_stb_i;
    expire = (TIMEOUT != 0) && mst_stb && (cnt == TMO) && !s_ack_i && !s_err_i;
  end

  // Combinational bus steering for the granted master
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !expire;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || expire;
        grant_o  = 2'b01;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !expire;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || expire;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

  // Grant state and last-served pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == GNT0 && state_nxt != GNT0) last <= 1'b0;
      if (state == GNT1 && state_nxt != GNT1) last <= 1'b1;
    end
  end

  // Stall counter: counts unanswered strobe cycles within one grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((TIMEOUT == 0) || (state == IDLE) || (state_nxt != state) ||
                 !mst_stb || s_ack_i || s_err_i || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone B3 classic arbiter sharing the SoC slave bus between the or1200 instruction (m0) and data (m1) Wishbone ports.
- Sits between or1200_top and the slave interconnect in orpsoc_top.
- Round-robin grant held for a whole bus cycle (cyc), with a bus watchdog that terminates hung slave accesses with err.

Parameters:
- DW, 32, data bus width.
- AW, 32, address bus width.
- TIMEOUT, 255, stalled-access cycles before the watchdog error (0 disables the watchdog); counter width is clog2(TIMEOUT+1), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_adr_i, m1_adr_i  in  AW  master address.
- m0_dat_i, m1_dat_i  in  DW  master write data.
- m0_sel_i, m1_sel_i  in  DW/8  byte selects.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_cyc_i, m1_cyc_i  in  1  bus cycle request.
- m0_stb_i, m1_stb_i  in  1  strobe.
- m0_dat_o, m1_dat_o  out  DW  read data.
- m0_ack_o, m1_ack_o  out  1  acknowledge.
- m0_err_o, m1_err_o  out  1  error.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_we_o, s_cyc_o, s_stb_o  out  1  slave controls.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i  in  1  slave ack/err.
- grant_o  out  2  one-hot current grant (bit n = master n); 00 when idle.

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-low.
- Reset state:
  - State IDLE; grant_o=00; last-served pointer=1, so m0 wins the first tie.
  - Watchdog counter=0.
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o=0.
  - All m*_ack_o and m*_err_o=0.
- States: IDLE, GNT0, GNT1; state is registered.
- Grant from IDLE (registered, 1-cycle arbitration latency):
  - Only m0_cyc_i=1 -> GNT0.
  - Only m1_cyc_i=1 -> GNT1.
  - Both asserted -> the master not equal to the last-served pointer.
  - Neither asserted -> stay IDLE.
- GNTn datapath (combinational, zero added latency):
  - s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o = master n's inputs.
  - mn_ack_o=s_ack_i, mn_err_o=s_err_i, mn_dat_o=s_dat_i.
  - The non-granted master sees ack=err=0 and dat_o=0.
- IDLE datapath: all slave outputs 0; all master ack/err 0.
- Grant hold and release:
  - Grant holds while mn_cyc_i=1, across multiple stb/ack beats (locked/burst cycles are never split).
  - At the edge where the granted master's cyc=0: go to GNT(other) if the other cyc=1 (direct handoff, no idle cycle), else IDLE.
  - Set last-served=n on leaving GNTn.
- Watchdog (TIMEOUT>0):
  - Counter increments each cycle in GNTn with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - Counter clears on ack, err, stb=0 or a state change.
  - When the counter equals TIMEOUT: mn_err_o=1 for exactly that cycle, s_stb_o forced to 0 that cycle, and the counter clears.
  - A late slave ack after the timeout is passed through as normal; masters are required to have dropped stb.
- Simultaneous events:
  - The granted master drops cyc while the other raises cyc in the same cycle -> handoff on that edge.
  - Slave ack and watchdog expiry in the same cycle -> ack wins, no err.
- Async reset mid-transfer: all outputs go to their reset values immediately (without waiting for a clock edge); grant is lost and the pointer returns to 1.
- No combinational path from s_ack_i/s_err_i to grant state other than through registered state.

Test Plan:
- Single m0 read: m0 cyc/stb, adr=0x100; slave acks 2 cycles later with dat=0xDEADBEEF -> grant_o=01 one cycle after request; m0_dat_o=0xDEADBEEF with m0_ack_o; m1_ack_o stays 0.
- Tie after reset: m0 and m1 raise cyc in the same cycle -> GNT0 first; on m0 cyc drop with m1 still requesting -> grant_o=10 on the next edge with no IDLE cycle.
- Round robin: both masters request continuously, each doing 1-beat cycles -> grants alternate 01,10,01,10; neither master is starved.
- Locked burst: m1 holds cyc for 4 acked beats while m0 requests -> grant stays 10 for all 4 beats; m0 granted only after m1 cyc=0.
- Watchdog: TIMEOUT=8, slave never acks on an m0 write -> m0_err_o=1 for exactly one cycle 8 cycles after stb; s_stb_o=0 in that cycle; ack-on-cycle-8 variant gives ack, no err.
- Reset mid-transfer: assert rst_n=0 during a GNT1 access -> grant_o=00 and s_cyc_o=0 before the next clock edge; after release, a simultaneous request grants m0.
